// File: rtl/btn_debounce_pair_pkg.sv
// Shared types and defaults for the two-channel button debouncer.
// Holds the per-channel FSM state enum and sizing constants.
package btn_debounce_pair_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    QUAL = 1'b1
  } dbc_state_e;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int PRESS_CNT_W         = 4;

endpackage

// File: rtl/btn_debounce_pair_if.sv
// Bundle of the debouncer pair's enable, raw inputs and clean outputs.
// master: drives ena/raw_in; slave: drives levels, pulses, counts.
interface btn_debounce_pair_if;

  logic       ena;
  logic [1:0] raw_in;
  logic [1:0] clean_out;
  logic [1:0] rise_pulse;
  logic [1:0] fall_pulse;
  logic [7:0] press_cnt;

  modport master (
    output ena,
    output raw_in,
    input  clean_out,
    input  rise_pulse,
    input  fall_pulse,
    input  press_cnt
  );

  modport slave (
    input  ena,
    input  raw_in,
    output clean_out,
    output rise_pulse,
    output fall_pulse,
    output press_cnt
  );

endinterface

// File: rtl/debounce_chan.sv
// One debounce channel: sync chain, IDLE/QUAL FSM, stable counter.
// Ports: clk, rst_n, ena, raw -> clean, rise, fall, press_cnt.
module debounce_chan
  import btn_debounce_pair_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   raw,
  output logic                   clean,
  output logic                   rise,
  output logic                   fall,
  output logic [PRESS_CNT_W-1:0] press_cnt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW:0] LIMIT = (CW+1)'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  dbc_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [PRESS_CNT_W-1:0] press_q, press_d;

  logic        synced;
  logic [CW:0] cnt_inc;

  assign synced  = sync_q[SYNC_STAGES-1];
  assign cnt_inc = {1'b0, cnt_q} + (CW+1)'(1);

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    press_d = press_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (synced != clean_q) begin
            state_d = QUAL;
            cnt_d   = CW'(1);
          end
        end
        QUAL: begin
          if (synced == clean_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_inc >= LIMIT) begin
            // The cycle in progress is the last stable one
            state_d = IDLE;
            cnt_d   = '0;
            clean_d = ~clean_q;
            rise_d  = ~clean_q;
            fall_d  = clean_q;
            if (!clean_q) begin
              press_d = press_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_inc[CW-1:0];
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      press_q <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      press_q <= press_d;
    end
  end

  assign clean     = clean_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign press_cnt = press_q;

endmodule

// File: rtl/btn_debounce_pair.sv
// Two independent debounce channels feeding NAND inputs A (bit0) / B (bit1).
// Ports: clk, rst_n, ena, raw_in[1:0] -> clean_out, pulses, press_cnt.
module btn_debounce_pair
  import btn_debounce_pair_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [1:0] raw_in,
  output logic [1:0] clean_out,
  output logic [1:0] rise_pulse,
  output logic [1:0] fall_pulse,
  output logic [7:0] press_cnt
);

  debounce_chan #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_ch0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .raw       (raw_in[0]),
    .clean     (clean_out[0]),
    .rise      (rise_pulse[0]),
    .fall      (fall_pulse[0]),
    .press_cnt (press_cnt[3:0])
  );

  debounce_chan #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_ch1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .raw       (raw_in[1]),
    .clean     (clean_out[1]),
    .rise      (rise_pulse[1]),
    .fall      (fall_pulse[1]),
    .press_cnt (press_cnt[7:4])
  );

endmodule
